// File: rtl/cpu_pkg.sv
// Shared RV32I core definitions: datapath widths, ALU op codes, ID->EXE control bundle.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int REG_ADDR_W = 5;
  localparam int CTRL_W     = 5;

  // ALU operation codes, shared with the ALU ctrl input decode.
  localparam logic [CTRL_W-1:0] ALU_ADD  = 5'd0;
  localparam logic [CTRL_W-1:0] ALU_SUB  = 5'd1;
  localparam logic [CTRL_W-1:0] ALU_SLL  = 5'd2;
  localparam logic [CTRL_W-1:0] ALU_SLT  = 5'd3;
  localparam logic [CTRL_W-1:0] ALU_SLTU = 5'd4;
  localparam logic [CTRL_W-1:0] ALU_XOR  = 5'd5;
  localparam logic [CTRL_W-1:0] ALU_SRL  = 5'd6;
  localparam logic [CTRL_W-1:0] ALU_SRA  = 5'd7;
  localparam logic [CTRL_W-1:0] ALU_OR   = 5'd8;
  localparam logic [CTRL_W-1:0] ALU_AND  = 5'd9;

  typedef struct packed {
    logic [CTRL_W-1:0] alu_ctrl;
    logic              alu_src_imm;
    logic              mem_read;
    logic              mem_write;
    logic              reg_write;
  } id_exe_ctrl_t;

endpackage

// File: rtl/exe_fwd_mux.sv
// Per-operand forward select: EX/MEM result, else MEM/WB result, else registered value.
// Latency: purely combinational, zero cycles.
// Backpressure: none; follows its inputs every cycle.
// Ports: i_rs_addr/i_rs_data  registered source operand
//        i_exmem_*            EX/MEM forward source (higher priority, youngest producer)
//        i_memwb_*            MEM/WB forward source
//        o_data               selected operand value
module exe_fwd_mux #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] i_rs_addr,
  input  logic [DATA_WIDTH-1:0] i_rs_data,
  input  logic                  i_exmem_reg_write,
  input  logic [REG_ADDR_W-1:0] i_exmem_rd_addr,
  input  logic [DATA_WIDTH-1:0] i_exmem_data,
  input  logic                  i_memwb_reg_write,
  input  logic [REG_ADDR_W-1:0] i_memwb_rd_addr,
  input  logic [DATA_WIDTH-1:0] i_memwb_data,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic w_exmem_hit;
  logic w_memwb_hit;

  // A producer targeting x0 never matches, so x0 reads keep the register-file zero.
  assign w_exmem_hit = i_exmem_reg_write && (i_exmem_rd_addr != '0) &&
                       (i_exmem_rd_addr == i_rs_addr);
  assign w_memwb_hit = i_memwb_reg_write && (i_memwb_rd_addr != '0) &&
                       (i_memwb_rd_addr == i_rs_addr);

  always_comb begin
    o_data = i_rs_data;
    if (w_exmem_hit) begin
      o_data = i_exmem_data;
    end else if (w_memwb_hit) begin
      o_data = i_memwb_data;
    end
  end

endmodule

// File: rtl/id_exe_stage.sv
// ID/EXE pipeline register with operand forwarding and load-use hazard detection.
// Latency: 1 cycle ID->EXE; forwarding into the ALU operands adds no cycles.
// Backpressure: stall holds EXE (refreshing held operands from MEM/WB); load-use inserts a bubble and asserts load_use_stall to hold ID.
// Ports: clk/rst        core clock, synchronous active-high reset
//        id_*           decoded instruction from ID
//        stall/flush    downstream hold / redirect kill
//        exmem_*/memwb_* forward sources
//        exe_*          registered and forwarded EXE-stage outputs
//        load_use_stall to IF/ID: hold PC and IF/ID register
module id_exe_stage #(
  parameter int DATA_WIDTH = cpu_pkg::DATA_WIDTH,
  parameter int REG_ADDR_W = cpu_pkg::REG_ADDR_W,
  parameter int CTRL_W     = cpu_pkg::CTRL_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [DATA_WIDTH-1:0] id_pc,
  input  logic [DATA_WIDTH-1:0] id_rs1_data,
  input  logic [DATA_WIDTH-1:0] id_rs2_data,
  input  logic [DATA_WIDTH-1:0] id_imm,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr,
  input  logic [REG_ADDR_W-1:0] id_rd_addr,
  input  logic [CTRL_W-1:0]     id_alu_ctrl,
  input  logic                  id_alu_src_imm,
  input  logic                  id_mem_read,
  input  logic                  id_mem_write,
  input  logic                  id_reg_write,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  exmem_reg_write,
  input  logic [REG_ADDR_W-1:0] exmem_rd_addr,
  input  logic [DATA_WIDTH-1:0] exmem_alu_out,
  input  logic                  memwb_reg_write,
  input  logic [REG_ADDR_W-1:0] memwb_rd_addr,
  input  logic [DATA_WIDTH-1:0] memwb_wb_data,
  output logic                  exe_valid,
  output logic [DATA_WIDTH-1:0] exe_pc,
  output logic [CTRL_W-1:0]     exe_alu_ctrl,
  output logic [DATA_WIDTH-1:0] exe_alu_a,
  output logic [DATA_WIDTH-1:0] exe_alu_b,
  output logic [DATA_WIDTH-1:0] exe_store_data,
  output logic [REG_ADDR_W-1:0] exe_rd_addr,
  output logic                  exe_mem_read,
  output logic                  exe_mem_write,
  output logic                  exe_reg_write,
  output logic                  load_use_stall
);

  import cpu_pkg::*;

  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] r_rs1_data;
  logic [DATA_WIDTH-1:0] r_rs2_data;
  logic [DATA_WIDTH-1:0] r_imm;
  logic [REG_ADDR_W-1:0] r_rs1_addr;
  logic [REG_ADDR_W-1:0] r_rs2_addr;
  logic [REG_ADDR_W-1:0] r_rd_addr;
  id_exe_ctrl_t          r_ctrl;

  id_exe_ctrl_t          w_id_ctrl;
  logic                  w_load_use;
  logic                  w_src_hit;
  logic                  w_kill;
  logic [DATA_WIDTH-1:0] w_fwd_rs1;
  logic [DATA_WIDTH-1:0] w_fwd_rs2;

  assign w_id_ctrl = '{alu_ctrl:    id_alu_ctrl,
                       alu_src_imm: id_alu_src_imm,
                       mem_read:    id_mem_read,
                       mem_write:   id_mem_write,
                       reg_write:   id_reg_write};

  // rs2 is compared even for immediate forms: a spurious bubble is cheaper
  // than decoding which instructions really read rs2.
  assign w_src_hit  = (id_rs1_addr == r_rd_addr) || (id_rs2_addr == r_rd_addr);
  assign w_load_use = !flush && r_valid && r_ctrl.mem_read &&
                      (r_rd_addr != '0) && id_valid && w_src_hit;

  // Reset, flush and a load-use bubble all leave EXE empty. The bubble only
  // applies when not stalled, since a stall must keep EXE contents intact.
  assign w_kill = rst || flush || (!stall && w_load_use);

  always_ff @(posedge clk) begin
    if (w_kill) begin
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_rs1_addr <= '0;
      r_rs2_addr <= '0;
      r_rd_addr  <= '0;
      r_ctrl     <= '0;
    end else if (stall) begin
      // A write retiring from MEM/WB during the hold would otherwise be gone
      // (and missing from the forward sources) when the stall releases.
      if (memwb_reg_write && (memwb_rd_addr != '0)) begin
        if (memwb_rd_addr == r_rs1_addr) r_rs1_data <= memwb_wb_data;
        if (memwb_rd_addr == r_rs2_addr) r_rs2_data <= memwb_wb_data;
      end
    end else begin
      r_valid    <= id_valid;
      r_pc       <= id_pc;
      r_rs1_data <= id_rs1_data;
      r_rs2_data <= id_rs2_data;
      r_imm      <= id_imm;
      r_rs1_addr <= id_rs1_addr;
      r_rs2_addr <= id_rs2_addr;
      r_rd_addr  <= id_rd_addr;
      r_ctrl     <= w_id_ctrl;
    end
  end

  exe_fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs1 (
    .i_rs_addr         (r_rs1_addr),
    .i_rs_data         (r_rs1_data),
    .i_exmem_reg_write (exmem_reg_write),
    .i_exmem_rd_addr   (exmem_rd_addr),
    .i_exmem_data      (exmem_alu_out),
    .i_memwb_reg_write (memwb_reg_write),
    .i_memwb_rd_addr   (memwb_rd_addr),
    .i_memwb_data      (memwb_wb_data),
    .o_data            (w_fwd_rs1)
  );

  exe_fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs2 (
    .i_rs_addr         (r_rs2_addr),
    .i_rs_data         (r_rs2_data),
    .i_exmem_reg_write (exmem_reg_write),
    .i_exmem_rd_addr   (exmem_rd_addr),
    .i_exmem_data      (exmem_alu_out),
    .i_memwb_reg_write (memwb_reg_write),
    .i_memwb_rd_addr   (memwb_rd_addr),
    .i_memwb_data      (memwb_wb_data),
    .o_data            (w_fwd_rs2)
  );

  assign exe_valid      = r_valid;
  assign exe_pc         = r_pc;
  assign exe_alu_ctrl   = r_ctrl.alu_ctrl;
  assign exe_alu_a      = w_fwd_rs1;
  assign exe_alu_b      = r_ctrl.alu_src_imm ? r_imm : w_fwd_rs2;
  assign exe_store_data = w_fwd_rs2;
  assign exe_rd_addr    = r_rd_addr;
  assign exe_mem_read   = r_ctrl.mem_read  && r_valid;
  assign exe_mem_write  = r_ctrl.mem_write && r_valid;
  assign exe_reg_write  = r_ctrl.reg_write && r_valid;
  assign load_use_stall = w_load_use;

endmodule

// File: tb/tb_id_exe_stage.sv
module tb_id_exe_stage;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 5;

  localparam logic [CW-1:0] OP_ADD = 5'd0;
  localparam logic [CW-1:0] OP_SUB = 5'd1;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid;
  logic [DW-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [AW-1:0] id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic [CW-1:0] id_alu_ctrl;
  logic          id_alu_src_imm, id_mem_read, id_mem_write, id_reg_write;
  logic          stall, flush;
  logic          exmem_reg_write;
  logic [AW-1:0] exmem_rd_addr;
  logic [DW-1:0] exmem_alu_out;
  logic          memwb_reg_write;
  logic [AW-1:0] memwb_rd_addr;
  logic [DW-1:0] memwb_wb_data;
  logic          exe_valid;
  logic [DW-1:0] exe_pc, exe_alu_a, exe_alu_b, exe_store_data;
  logic [CW-1:0] exe_alu_ctrl;
  logic [AW-1:0] exe_rd_addr;
  logic          exe_mem_read, exe_mem_write, exe_reg_write, load_use_stall;

  always #5 clk = ~clk;

  id_exe_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
    .id_alu_ctrl(id_alu_ctrl), .id_alu_src_imm(id_alu_src_imm),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_reg_write(id_reg_write),
    .stall(stall), .flush(flush),
    .exmem_reg_write(exmem_reg_write), .exmem_rd_addr(exmem_rd_addr), .exmem_alu_out(exmem_alu_out),
    .memwb_reg_write(memwb_reg_write), .memwb_rd_addr(memwb_rd_addr), .memwb_wb_data(memwb_wb_data),
    .exe_valid(exe_valid), .exe_pc(exe_pc), .exe_alu_ctrl(exe_alu_ctrl),
    .exe_alu_a(exe_alu_a), .exe_alu_b(exe_alu_b), .exe_store_data(exe_store_data),
    .exe_rd_addr(exe_rd_addr), .exe_mem_read(exe_mem_read), .exe_mem_write(exe_mem_write),
    .exe_reg_write(exe_reg_write), .load_use_stall(load_use_stall)
  );

  typedef enum int {F_VALID, F_PC, F_A, F_B, F_SD, F_RD, F_MR, F_MW, F_RW, F_LUS, F_CTRL} fsel_t;
  typedef struct {
    string       name;
    int          cyc;
    fsel_t       f;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cnt = 0;

  always @(posedge clk) cnt <= cnt + 1;

  function automatic logic [31:0] actual(fsel_t f);
    case (f)
      F_VALID: return {31'd0, exe_valid};
      F_PC:    return exe_pc;
      F_A:     return exe_alu_a;
      F_B:     return exe_alu_b;
      F_SD:    return exe_store_data;
      F_RD:    return {27'd0, exe_rd_addr};
      F_MR:    return {31'd0, exe_mem_read};
      F_MW:    return {31'd0, exe_mem_write};
      F_RW:    return {31'd0, exe_reg_write};
      F_LUS:   return {31'd0, load_use_stall};
      F_CTRL:  return {27'd0, exe_alu_ctrl};
      default: return 32'hxxxxxxxx;
    endcase
  endfunction

  // Expectation for the DUT outputs in the current cycle.
  task automatic chk(input string n, input fsel_t f, input logic [31:0] v);
    exp_t e;
    e.name = n;
    e.cyc  = cnt;
    e.f    = f;
    e.val  = v;
    sb.push_back(e);
  endtask

  // Monitor: samples on the falling edge, pops every expectation due this cycle.
  exp_t        m_e;
  logic [31:0] m_act;
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cnt) begin
      m_e = sb.pop_front();
      checks++;
      if (m_e.cyc != cnt) begin
        errors++;
        $display("FAIL %s: expectation for cycle %0d not sampled (now %0d)", m_e.name, m_e.cyc, cnt);
      end else begin
        m_act = actual(m_e.f);
        if (m_act !== m_e.val) begin
          errors++;
          $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", m_e.name, m_act, m_e.val, cnt);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(input logic v, input logic [31:0] pc, input logic [31:0] rs1d,
                          input logic [31:0] rs2d, input logic [31:0] imm,
                          input logic [4:0] rs1a, input logic [4:0] rs2a, input logic [4:0] rda,
                          input logic [4:0] ctrl, input logic si, input logic mr,
                          input logic mw, input logic rw);
    id_valid = v; id_pc = pc; id_rs1_data = rs1d; id_rs2_data = rs2d; id_imm = imm;
    id_rs1_addr = rs1a; id_rs2_addr = rs2a; id_rd_addr = rda; id_alu_ctrl = ctrl;
    id_alu_src_imm = si; id_mem_read = mr; id_mem_write = mw; id_reg_write = rw;
  endtask

  task automatic fwd(input logic ew, input logic [4:0] ea, input logic [31:0] ed,
                     input logic ww, input logic [4:0] wa, input logic [31:0] wd);
    exmem_reg_write = ew; exmem_rd_addr = ea; exmem_alu_out = ed;
    memwb_reg_write = ww; memwb_rd_addr = wa; memwb_wb_data = wd;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    drive_id(0, 0, 0, 0, 0, 0, 0, 0, OP_ADD, 0, 0, 0, 0);
    fwd(0, 0, 0, 0, 0, 0);
    step(); step();

    // Load garbage, then reset over it.
    rst = 1'b0;
    drive_id(1, 32'hDEADBEEF, 32'h1234, 32'h5678, 32'h9ABC, 7, 7, 7, 5'd9, 1, 1, 1, 1);
    step();
    rst = 1'b1;
    step();
    chk("rst_valid", F_VALID, 0); chk("rst_pc", F_PC, 0);   chk("rst_a", F_A, 0);
    chk("rst_b", F_B, 0);         chk("rst_sd", F_SD, 0);   chk("rst_rd", F_RD, 0);
    chk("rst_mr", F_MR, 0);       chk("rst_mw", F_MW, 0);   chk("rst_rw", F_RW, 0);
    chk("rst_lus", F_LUS, 0);     chk("rst_ctrl", F_CTRL, 0);

    // add x3, x1, x2 with x1=5, x2=7
    rst = 1'b0;
    drive_id(1, 32'h100, 5, 7, 0, 1, 2, 3, OP_ADD, 0, 0, 0, 1);
    step();
    drive_id(0, 0, 0, 0, 0, 0, 0, 0, OP_ADD, 0, 0, 0, 0);
    stall = 1'b1;
    fwd(1, 1, 100, 0, 0, 0);
    chk("exmem_fwd_a", F_A, 100); chk("add_b", F_B, 7);  chk("add_sd", F_SD, 7);
    chk("add_pc", F_PC, 32'h100); chk("add_rd", F_RD, 3); chk("add_rw", F_RW, 1);
    chk("add_valid", F_VALID, 1);
    step();
    fwd(1, 1, 200, 1, 1, 300);
    chk("exmem_over_memwb", F_A, 200);
    step();
    // MEM/WB x1=300 was absorbed into the held rs1 during the stall.
    stall = 1'b0;
    fwd(0, 0, 0, 0, 0, 0);
    chk("stall_refresh_rs1", F_A, 300); chk("refresh_b", F_B, 7);
    drive_id(1, 32'h104, 0, 9, 32'hFFFFFFFC, 0, 2, 8, OP_SUB, 1, 0, 0, 1);
    step();

    // x0 never forwarded; imm selects operand B; rs2 forwarded from MEM/WB into store data.
    fwd(1, 0, 99, 1, 2, 32'h55);
    chk("x0_no_fwd", F_A, 0);    chk("imm_b", F_B, 32'hFFFFFFFC);
    chk("memwb_fwd_sd", F_SD, 32'h55); chk("sub_ctrl", F_CTRL, OP_SUB);
    chk("sub_rd", F_RD, 8);
    drive_id(1, 32'h200, 32'h1000, 0, 8, 1, 0, 4, OP_ADD, 1, 1, 0, 1); // lw x4, 8(x1)
    step();

    // Load-use: add x6, x4, x7 behind lw x4
    fwd(0, 0, 0, 0, 0, 0);
    drive_id(1, 32'h204, 0, 3, 0, 4, 7, 6, OP_ADD, 0, 0, 0, 1);
    chk("lus_rs1", F_LUS, 1); chk("lw_mr", F_MR, 1); chk("lw_valid", F_VALID, 1);
    step();
    chk("bubble_valid", F_VALID, 0); chk("bubble_lus", F_LUS, 0);
    chk("bubble_mr", F_MR, 0);       chk("bubble_rw", F_RW, 0);
    step();
    fwd(0, 0, 0, 1, 4, 32'hDEAD);
    chk("load_fwd_a", F_A, 32'hDEAD); chk("lu_b", F_B, 3);
    chk("lu_pc", F_PC, 32'h204);      chk("lu_rd", F_RD, 6);
    chk("lu_valid", F_VALID, 1);
    drive_id(1, 32'h300, 0, 0, 16, 2, 0, 5, OP_ADD, 1, 1, 0, 1); // lw x5, 16(x2)
    step();

    // addi x10, x9 with rs2 field = x5: conservative match; then flush over stall.
    fwd(0, 0, 0, 0, 0, 0);
    drive_id(1, 32'h304, 32'h11, 0, 1, 9, 5, 10, OP_ADD, 1, 0, 0, 1);
    stall = 1'b1;
    chk("lus_rs2_imm", F_LUS, 1);
    step();
    flush = 1'b1;
    chk("flush_forces_lus0", F_LUS, 0);
    step();
    flush = 1'b0; stall = 1'b0;
    chk("flush_valid", F_VALID, 0); chk("flush_rw", F_RW, 0); chk("flush_lus", F_LUS, 0);
    drive_id(1, 32'h400, 32'h300, 1, 4, 1, 5, 0, OP_ADD, 1, 0, 1, 0); // sw x5, 4(x1)
    step();

    // Stall three cycles holding rs2=x5; MEM/WB retires x5=42 in the middle one.
    drive_id(0, 0, 0, 0, 0, 0, 0, 0, OP_ADD, 0, 0, 0, 0);
    stall = 1'b1;
    chk("sw_sd_stale", F_SD, 1); chk("sw_mw", F_MW, 1);
    step();
    fwd(0, 0, 0, 1, 5, 42);
    chk("sw_sd_fwd", F_SD, 42);
    step();
    fwd(0, 0, 0, 0, 0, 0);
    chk("sw_sd_held", F_SD, 42);
    step();
    stall = 1'b0;
    chk("sw_sd_release", F_SD, 42); chk("sw_b", F_B, 4);
    chk("sw_mw_rel", F_MW, 1);      chk("sw_valid", F_VALID, 1);
    step();
    chk("idle_mw", F_MW, 0); chk("idle_valid", F_VALID, 0);
    step();
    step();

    if (sb.size() != 0) begin
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", sb.size());
      checks += sb.size();
      errors += sb.size();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_exe_stage.md
Name: id_exe_stage

Overview:
- ID/EXE pipeline register for the 5-stage RV32I core, feeding the EXE ALU.
- Captures decoded operands and control from ID.
- Forwards results from EX/MEM and MEM/WB into the ALU operand inputs.
- Detects load-use hazards and inserts a one-cycle bubble while ID holds; honours external stall and flush.

Parameters:
- DATA_WIDTH, 32, operand/PC width
- REG_ADDR_W, 5, register index width
- CTRL_W, 5, ALU control width (matches ALU ctrl input)

Ports:
- clk  in  1  core clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_pc  in  DATA_WIDTH  PC of ID instruction
- id_rs1_data, id_rs2_data  in  DATA_WIDTH  register file read data
- id_imm  in  DATA_WIDTH  sign-extended immediate
- id_rs1_addr, id_rs2_addr, id_rd_addr  in  REG_ADDR_W  register indices
- id_alu_ctrl  in  CTRL_W  ALU operation code
- id_alu_src_imm  in  1  ALU operand B = imm when 1
- id_mem_read, id_mem_write, id_reg_write  in  1  decoded control
- stall  in  1  downstream (MEM) stall; hold EXE contents
- flush  in  1  branch/jump redirect; kill EXE contents
- exmem_reg_write  in  1, exmem_rd_addr  in  REG_ADDR_W, exmem_alu_out  in  DATA_WIDTH  EX/MEM forward source
- memwb_reg_write  in  1, memwb_rd_addr  in  REG_ADDR_W, memwb_wb_data  in  DATA_WIDTH  MEM/WB forward source
- exe_valid  out  1  EXE holds a real instruction
- exe_pc  out  DATA_WIDTH
- exe_alu_ctrl  out  CTRL_W  to ALU ctrl
- exe_alu_a, exe_alu_b  out  DATA_WIDTH  forwarded operands to ALU rs1/rs2
- exe_store_data  out  DATA_WIDTH  forwarded rs2 value (for stores)
- exe_rd_addr  out  REG_ADDR_W
- exe_mem_read, exe_mem_write, exe_reg_write  out  1  gated by exe_valid
- load_use_stall  out  1  to IF/ID: hold PC and IF/ID register

Behaviour:
- Reset (rst=1 at edge): every register cleared to 0; exe_valid=0. All outputs are then 0.
- Update priority per edge: rst > flush > stall > load_use_stall > normal load.
  - flush: exe_valid<=0; other fields don't-care (cleared to 0).
  - stall: all registers hold, except for the stall-hold refresh rule below.
  - load_use_stall (stall=0): bubble, exe_valid<=0.
  - Normal: capture all id_* fields; exe_valid<=id_valid.
- load_use_stall is combinational. It is 1 iff all of the following hold:
  - exe_valid & exe_mem_read
  - exe_rd_addr != 0
  - id_valid
  - id_rs1_addr==exe_rd_addr, or id_rs2_addr==exe_rd_addr (the rs2 match is considered even for immediate forms; conservative)
- load_use_stall is forced 0 when flush=1.
- Forwarding is combinational, per source operand (rs1, rs2), using the registered exe_rs*_addr:
  - If exmem_reg_write & exmem_rd_addr!=0 & match: use exmem_alu_out.
  - Else if memwb_reg_write & memwb_rd_addr!=0 & match: use memwb_wb_data.
  - Else: use the registered data.
  - EX/MEM has priority, so the youngest producer wins.
- Operand selection:
  - exe_alu_a = forwarded rs1.
  - exe_alu_b = registered imm if alu_src_imm, else forwarded rs2.
  - exe_store_data = forwarded rs2 always.
- Stall-hold refresh: while stall=1, if memwb_reg_write & memwb_rd_addr!=0 & memwb_rd_addr matches a held rs*_addr, that held rs*_data register is overwritten with memwb_wb_data. This prevents losing a retiring write.
- Address x0: never forwarded; registered data for x0 is used as is (register file returns 0).
- Register file is write-first. A same-cycle WB to an ID read is resolved by the register file, not here.
- Latency: 1 cycle ID->EXE. Forwarding adds no cycles.
- Output gating: exe_mem_read, exe_mem_write and exe_reg_write are ANDed with exe_valid.

Decomposition:
- Shared package cpu_pkg:
  - DATA_WIDTH / REG_ADDR_W constants
  - ALU ctrl localparams (ADD..AND)
  - typedef struct id_exe_ctrl_t {alu_ctrl, alu_src_imm, mem_read, mem_write, reg_write}
- One sub-module: exe_fwd_mux, the per-operand priority forward select, instantiated twice.

Test Plan:
- rst=1 one cycle after loading garbage -> all outputs 0, load_use_stall=0.
- ID: add x3 with x1=5, x2=7; next cycle exmem writes x1=100 -> exe_alu_a=100, exe_alu_b=7.
- exmem and memwb both write x1 (200 vs 300) -> exe_alu_a=200.
- EXE holds lw x4; ID reads rs1=x4 -> load_use_stall=1; next edge exe_valid=0 and ID unchanged; following cycle memwb x4=0xDEAD forwards to exe_alu_a=0xDEAD.
- flush=1 together with stall=1 and load-use -> next cycle exe_valid=0, exe_reg_write=0, load_use_stall=0.
- stall=1 for 3 cycles holding rs2=x5; memwb writes x5=42 in cycle 2 -> after stall release, exe_store_data=42 with no forward active.
